// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for an SRAM-backed FIFO: credit-limited read issue, tag pipeline, skid buffer.
// Optional transfer counter on output word_cnt when FIFO_RD_STREAM_CNT_EN is defined.
module fifo_rd_stream #(
  parameter int DATA_SIZE = 16,
  parameter int RD_LAT    = 2,
  parameter int BUF_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 en,
  input  logic                 fifo_empty,
  output logic                 fifo_rd,
  input  logic [DATA_SIZE-1:0] fifo_dout,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 busy
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [15:0]          word_cnt
`endif
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(BUF_DEPTH + RD_LAT + 1);

  logic [RD_LAT-1:0]    tag_r;
  logic [DATA_SIZE-1:0] mem_r [BUF_DEPTH];
  logic [AW-1:0]        wptr_r;
  logic [AW-1:0]        rptr_r;
  logic [CW-1:0]        count_r;
  logic [SW-1:0]        outstanding_s;
  logic [SW-1:0]        credit_sum_s;
  logic                 capture_s;
  logic                 pop_s;

  // Count reads in flight; credit uses registered count only, so a same-cycle pop is ignored.
  always_comb begin
    outstanding_s = {SW{1'b0}};
    for (int i = 0; i < RD_LAT; i++) begin
      outstanding_s = outstanding_s + SW'(tag_r[i]);
    end
    credit_sum_s = SW'(count_r) + outstanding_s;
  end

  assign fifo_rd   = en & ~fifo_empty & (credit_sum_s < SW'(BUF_DEPTH));
  assign capture_s = tag_r[RD_LAT-1];
  assign m_valid   = (count_r != {CW{1'b0}});
  assign pop_s     = m_valid & m_ready;
  assign m_data    = mem_r[rptr_r];
  assign busy      = (outstanding_s != {SW{1'b0}}) | m_valid;

  // Tag shift register tracking the SRAM read latency.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_r <= {RD_LAT{1'b0}};
    end else begin
      tag_r[0] <= fifo_rd;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  // Skid buffer storage; cleared on reset so m_data reads zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_r[i] <= {DATA_SIZE{1'b0}};
      end
    end else if (capture_s) begin
      mem_r[wptr_r] <= fifo_dout;
    end
  end

  // Write/read pointers wrap naturally since BUF_DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_r <= {AW{1'b0}};
      rptr_r <= {AW{1'b0}};
    end else begin
      if (capture_s) begin
        wptr_r <= wptr_r + AW'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + AW'(1);
      end
    end
  end

  // Occupancy: capture and pop in the same cycle leave it unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_r <= {CW{1'b0}};
    end else begin
      case ({capture_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [15:0] word_cnt_r;

  // Free-running stream transfer counter, wraps 0xFFFF to 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      word_cnt_r <= 16'h0000;
    end else if (pop_s) begin
      word_cnt_r <= word_cnt_r + 16'h0001;
    end
  end

  assign word_cnt = word_cnt_r;
`else
  // Default build carries no transfer counter.
`endif

endmodule
